// File: rtl/ext_mem_l2_sched_if.sv
// Bundle of the L1 back-end buses, the L2 native front-end and the invalidate handshake
// shared by the L2 scheduler. The slave modport is the scheduler's view; the master modport is its environment's view.
interface ext_mem_l2_sched_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS*STRB_W-1:0] m_wstrb;
  logic [N_MASTERS*DATA_W-1:0] m_rdata;
  logic [N_MASTERS-1:0]        m_ready;
  logic                        s_valid;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic [STRB_W-1:0]           s_wstrb;
  logic [DATA_W-1:0]           s_rdata;
  logic                        s_ready;
  logic                        inv_req;
  logic                        wtb_empty;
  logic                        s_force_inv;
  logic                        inv_ack;
  logic                        busy;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready, inv_req, wtb_empty,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, s_force_inv, inv_ack, busy
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready, inv_req, wtb_empty,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, s_force_inv, inv_ack, busy
  );
endinterface

// File: rtl/ext_mem_l2_sched.sv
// Round-robin scheduler of the shared L2 native front-end with per-transaction grant locking,
// plus the invalidate sequence (block grants, drain write-through buffer, pulse force-invalidate).
module ext_mem_l2_sched #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ext_mem_l2_sched_if.slave      bus
);
  localparam int unsigned GW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned SW   = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_INV   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic          inv_pending_q, inv_pending_d;
  logic          found;
  logic [GW-1:0] sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      inv_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      inv_pending_q <= inv_pending_d;
    end
  end

  // Round-robin pick: first valid at or above the pointer, else lowest valid below it
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && bus.m_valid[i] && (GW'(i) >= rr_q)) begin
        found = 1'b1;
        sel   = GW'(i);
      end
    end
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (!found && bus.m_valid[i]) begin
        found = 1'b1;
        sel   = GW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    inv_pending_d = inv_pending_q | bus.inv_req;
    case (state_q)
      S_IDLE: begin
        if (inv_pending_q || bus.inv_req) begin
          state_d = S_DRAIN;
        end else if (found) begin
          grant_d = sel;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.s_ready) begin
          rr_d    = (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + GW'(1);
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.wtb_empty) state_d = S_INV;
      end
      S_INV: begin
        inv_pending_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Front-end mux and completion routing; everything reads zero outside BUSY
  always_comb begin
    bus.s_valid     = (state_q == S_BUSY);
    bus.s_addr      = '0;
    bus.s_wdata     = '0;
    bus.s_wstrb     = '0;
    bus.m_ready     = '0;
    bus.s_force_inv = (state_q == S_INV);
    bus.inv_ack     = (state_q == S_INV);
    bus.busy        = (state_q != S_IDLE);
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if ((state_q == S_BUSY) && (grant_q == GW'(i))) begin
        bus.s_addr     = bus.m_addr[i*ADDR_W +: ADDR_W];
        bus.s_wdata    = bus.m_wdata[i*DATA_W +: DATA_W];
        bus.s_wstrb    = bus.m_wstrb[i*SW +: SW];
        bus.m_ready[i] = bus.s_ready;
      end
    end
  end

  assign bus.m_rdata = {N_MASTERS{bus.s_rdata}};

endmodule

// File: tb/tb_ext_mem_l2_sched.sv
// Scoreboard bench for ext_mem_l2_sched: per-master expected queues filled at request time,
// drained by a completion monitor; scenario tasks check timing and invalidate sequencing.
`timescale 1ns/1ps
module tb_ext_mem_l2_sched;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unsigned l2_lat = 0;
  int unsigned l2_cnt = 0;
  int inv_cnt = 0;
  int inv_cyc = 0;
  int done_cyc [N];
  sb_t sbq0 [$];
  sb_t sbq1 [$];
  int order [$];

  ext_mem_l2_sched_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ext_mem_l2_sched #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // L2 model: s_ready after l2_lat further cycles of s_valid, data from rd_model
  initial begin
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || !bus.s_valid || bus.s_ready) begin
        bus.s_ready = 1'b0;
        l2_cnt      = 0;
      end else begin
        l2_cnt++;
        if (l2_cnt > l2_lat) begin
          bus.s_ready = 1'b1;
          bus.s_rdata = rd_model(bus.s_addr);
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard of the master that got m_ready
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!bus.s_valid && ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== '0)) begin
        errors++;
        $display("FAIL idle_bus_zero cyc %0d addr %h wdata %h wstrb %h required 0", cyc, bus.s_addr, bus.s_wdata, bus.s_wstrb);
      end
      checks++;
      if ((bus.s_valid && bus.s_force_inv) || (bus.s_force_inv !== bus.inv_ack)) begin
        errors++;
        $display("FAIL inv_outputs cyc %0d s_valid %b s_force_inv %b inv_ack %b", cyc, bus.s_valid, bus.s_force_inv, bus.inv_ack);
      end
      if (bus.s_force_inv) begin
        inv_cnt++;
        inv_cyc = cyc;
      end
      if (bus.m_ready !== '0) begin
        checks++;
        if ($countones(bus.m_ready) != 1 || bus.s_valid !== 1'b1) begin
          errors++;
          $display("FAIL ready_onehot cyc %0d m_ready %b s_valid %b required one-hot with s_valid", cyc, bus.m_ready, bus.s_valid);
        end
        for (int m = 0; m < int'(N); m++) begin
          if (bus.m_ready[m]) begin
            sb_t e;
            bit  have;
            have = (m == 0) ? (sbq0.size() != 0) : (sbq1.size() != 0);
            checks++;
            if (!have) begin
              errors++;
              $display("FAIL unexpected_ready cyc %0d master %0d had no outstanding request", cyc, m);
            end else begin
              if (m == 0) e = sbq0.pop_front();
              else        e = sbq1.pop_front();
              if (bus.s_addr !== e.addr || bus.s_wdata !== e.wdata || bus.s_wstrb !== e.wstrb ||
                  bus.m_rdata[m*DW +: DW] !== e.rdata) begin
                errors++;
                $display("FAIL completion m%0d cyc %0d got addr %h wdata %h wstrb %h rdata %h required %h %h %h %h",
                         m, cyc, bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.m_rdata[m*DW +: DW],
                         e.addr, e.wdata, e.wstrb, e.rdata);
              end
            end
            order.push_back(m);
            done_cyc[m] = cyc;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst           = 1'b1;
    bus.m_valid   = '0;
    bus.inv_req   = 1'b0;
    bus.wtb_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq0.delete();
    sbq1.delete();
  endtask

  // Issue one request from master m, hold it until its m_ready, then release
  task automatic req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    sb_t e;
    bit  seen;
    seen    = 1'b0;
    e.addr  = a;
    e.wdata = wd;
    e.wstrb = ws;
    e.rdata = rd_model(a);
    if (m == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
    bus.m_addr[m*AW +: AW]  = a;
    bus.m_wdata[m*DW +: DW] = wd;
    bus.m_wstrb[m*SW +: SW] = ws;
    bus.m_valid[m]          = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = bus.m_ready[m];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL req_timeout master %0d addr %h got no m_ready within 60 cycles", m, a);
    end
    @(posedge clk); #1;
    bus.m_valid[m] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus.s_valid, bus.busy, bus.s_force_inv, bus.inv_ack, bus.m_ready} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl s_valid %b busy %b force_inv %b inv_ack %b m_ready %b required all 0",
               bus.s_valid, bus.busy, bus.s_force_inv, bus.inv_ack, bus.m_ready);
    end
    checks++;
    if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_bus addr %h wdata %h wstrb %h required 0", bus.s_addr, bus.s_wdata, bus.s_wstrb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    sb_t e;
    int  t0;
    int  pulses;
    int  rcyc;
    pulses  = 0;
    rcyc    = -1;
    l2_lat  = 3;
    e.addr  = 32'h100;
    e.wdata = '0;
    e.wstrb = '0;
    e.rdata = 32'hDEADBEEF;
    sbq0.push_back(e);
    bus.m_addr[0 +: AW]  = 32'h100;
    bus.m_wdata[0 +: DW] = '0;
    bus.m_wstrb[0 +: SW] = '0;
    bus.m_valid[0]       = 1'b1;
    t0 = cyc;
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid s_valid %b required 0 in request cycle", bus.s_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 1'b1 || bus.s_addr !== 32'h100) begin
      errors++;
      $display("FAIL single_grant s_valid %b addr %h required 1 100", bus.s_valid, bus.s_addr);
    end
    for (int k = 0; k < 10; k++) begin
      if (bus.m_ready[0] === 1'b1) begin
        pulses++;
        rcyc = cyc;
        checks++;
        if (bus.m_rdata[DW +: DW] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rdata_broadcast slot1 %h required deadbeef", bus.m_rdata[DW +: DW]);
        end
      end
      @(posedge clk); #1;
      if (pulses != 0) bus.m_valid[0] = 1'b0;
      if (k != 9) @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_ready_pulses got %0d required 1", pulses);
    end
    checks++;
    if (rcyc != t0 + 4) begin
      errors++;
      $display("FAIL single_ready_cycle got %0d required %0d", rcyc, t0 + 4);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    l2_lat = 1;
    order.delete();
    fork
      begin
        for (int j = 0; j < 3; j++) req(0, 32'h200 + 32'(j * 4), '0, '0);
      end
      begin
        for (int j = 0; j < 3; j++) req(1, 32'h300 + 32'(j * 4), 32'hC0DE_0000 + 32'(j), 4'hF);
      end
    join
    checks++;
    if (order.size() != 6) begin
      errors++;
      $display("FAIL rr_count got %0d completions required 6", order.size());
    end
    for (int j = 0; j < 6 && j < order.size(); j++) begin
      checks++;
      if (order[j] != j % 2) begin
        errors++;
        $display("FAIL rr_order slot %0d got master %0d required %0d", j, order[j], j % 2);
      end
    end
  endtask

  task automatic test_inv_during_busy();
    int ic0;
    do_reset();
    l2_lat = 3;
    order.delete();
    ic0 = inv_cnt;
    fork
      req(1, 32'h400, 32'h1111_2222, 4'h3);
      begin
        bit sv;
        sv = 1'b0;
        for (int k = 0; k < 20 && !sv; k++) begin
          @(negedge clk);
          sv = bus.s_valid;
        end
        @(posedge clk); #1;
        bus.inv_req = 1'b1;
        @(posedge clk); #1;
        bus.inv_req = 1'b0;
        req(0, 32'h500, '0, '0);
      end
    join
    checks++;
    if (inv_cnt - ic0 != 1) begin
      errors++;
      $display("FAIL busy_inv_count got %0d required 1", inv_cnt - ic0);
    end
    checks++;
    if (inv_cyc != done_cyc[1] + 3) begin
      errors++;
      $display("FAIL busy_inv_cycle got %0d required %0d", inv_cyc, done_cyc[1] + 3);
    end
    checks++;
    if (done_cyc[0] != done_cyc[1] + 8) begin
      errors++;
      $display("FAIL busy_inv_m0_done got %0d required %0d", done_cyc[0], done_cyc[1] + 8);
    end
    checks++;
    if (order.size() != 2 || order[0] != 1) begin
      errors++;
      $display("FAIL busy_inv_order first completion not master 1 (count %0d)", order.size());
    end
  endtask

  task automatic test_inv_wtb_wait();
    int ic0;
    ic0 = inv_cnt;
    for (int k = 0; k < 9; k++) begin
      bus.inv_req   = (k == 0);
      bus.wtb_empty = (k >= 5);
      @(negedge clk);
      checks++;
      if (bus.busy !== (k >= 1 && k <= 6)) begin
        errors++;
        $display("FAIL wtb_busy step %0d got %b required %b", k, bus.busy, (k >= 1 && k <= 6));
      end
      checks++;
      if (bus.s_force_inv !== (k == 6) || bus.inv_ack !== (k == 6)) begin
        errors++;
        $display("FAIL wtb_inv step %0d force_inv %b inv_ack %b required %b", k, bus.s_force_inv, bus.inv_ack, (k == 6));
      end
      @(posedge clk); #1;
    end
    bus.inv_req   = 1'b0;
    bus.wtb_empty = 1'b1;
    checks++;
    if (inv_cnt - ic0 != 1) begin
      errors++;
      $display("FAIL wtb_inv_count got %0d required 1", inv_cnt - ic0);
    end
  endtask

  task automatic test_inv_collapse();
    int ic0;
    ic0 = inv_cnt;
    for (int k = 0; k < 12; k++) begin
      bus.inv_req   = (k == 0 || k == 2 || k == 4);
      bus.wtb_empty = (k >= 6);
      @(negedge clk);
      checks++;
      if (bus.s_force_inv !== (k == 7)) begin
        errors++;
        $display("FAIL collapse_inv step %0d got %b required %b", k, bus.s_force_inv, (k == 7));
      end
      @(posedge clk); #1;
    end
    bus.inv_req = 1'b0;
    checks++;
    if (inv_cnt - ic0 != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL collapse_count got %0d pulses busy %b required 1 pulse busy 0", inv_cnt - ic0, bus.busy);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit sv;
    l2_lat = 20;
    sv     = 1'b0;
    bus.m_addr[AW +: AW]  = 32'h600;
    bus.m_wdata[DW +: DW] = '0;
    bus.m_wstrb[SW +: SW] = '0;
    bus.m_valid[1]        = 1'b1;
    for (int k = 0; k < 20 && !sv; k++) begin
      @(negedge clk);
      sv = bus.s_valid;
    end
    checks++;
    if (!sv) begin
      errors++;
      $display("FAIL midrst_grant s_valid never rose for master 1");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.m_valid = '0;
    sbq0.delete();
    sbq1.delete();
    @(negedge clk);
    checks++;
    if (bus.s_valid !== 1'b0 || bus.m_ready !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs s_valid %b m_ready %b busy %b required 0", bus.s_valid, bus.m_ready, bus.busy);
    end
    @(posedge clk); #1;
    l2_lat = 1;
    order.delete();
    fork
      req(0, 32'h700, '0, '0);
      req(1, 32'h800, 32'hFACE_0001, 4'h1);
    join
    checks++;
    if (order.size() != 2 || order[0] != 0) begin
      errors++;
      $display("FAIL midrst_rr first completion not master 0 (count %0d)", order.size());
    end
  endtask

  initial begin
    bus.m_valid   = '0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.m_wstrb   = '0;
    bus.inv_req   = 1'b0;
    bus.wtb_empty = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_inv_during_busy();
    test_inv_wtb_wait();
    test_inv_collapse();
    test_reset_mid_busy();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
